mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port external memory between the CPU instruction-fetch
//   port and the load/store port, one transaction at a time. Data accesses win
//   by default; a starvation counter forces a fetch grant after STARVE_LIMIT
//   consecutive data grants made while fetch was waiting. An access that sees
//   no mem_ready for TIMEOUT cycles is aborted and reported with err.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   if_req/if_addr        fetch request (level, held until if_done) and address
//   if_done/if_rdata      fetch completion pulse and registered fetch data
//   d_req/d_we            data request (level, held until d_done), 1 = store
//   d_addr/d_wdata        data address and store data
//   d_done/d_rdata        data completion pulse and registered load data
//   err                   pulses with if_done/d_done when the access timed out
//   mem_req/mem_we        memory request (held until mem_ready) and write strobe
//   mem_addr/mem_wdata    address and store data latched at grant
//   mem_rdata/mem_ready   memory read data and access-complete strobe

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mem_port_arbiter #(
  parameter int unsigned W            = `WORD_WIDTH,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         if_req,
  input  logic [W-1:0] if_addr,
  output logic         if_done,
  output logic [W-1:0] if_rdata,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [W-1:0] d_addr,
  input  logic [W-1:0] d_wdata,
  output logic         d_done,
  output logic [W-1:0] d_rdata,
  output logic         err,
  output logic         mem_req,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata,
  input  logic         mem_ready
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  // Last wait_cnt value before the abort: mem_req stays up exactly TIMEOUT cycles.
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

  state_t     state;
  logic [3:0] starve_cnt;
  logic [7:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      err        <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (if_req && (starve_cnt == STARVE_MAX || !d_req)) begin
            state      <= FETCH;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            starve_cnt <= '0;
          end else if (d_req) begin
            state     <= DATA;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            // Only data grants that overtake a waiting fetch count toward starvation.
            if (!if_req)
              starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX)
              starve_cnt <= starve_cnt + 4'd1;
          end else begin
            starve_cnt <= '0;
          end
        end
        FETCH, DATA: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (state == FETCH) begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end else begin
              if (!mem_we)
                d_rdata <= mem_rdata;
              d_done <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == WAIT_LAST) begin
              state   <= IDLE;
              mem_req <= 1'b0;
              err     <= 1'b1;
              if (state == FETCH)
                if_done <= 1'b1;
              else
                d_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
